vt_strand_encoder: RTL and testbench

VT_STRAND_ENCODER -- requirements
Module: vt_strand_encoder

---
 rtl/vt_strand_encoder.sv | 173 +++++++++++++++++
 tb/tb_vt_strand_encoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vt_strand_encoder.sv
// Serial Varshamov-Tenengolts strand encoder.
// A K-bit message is spread over the non-power-of-two positions of an n-bit
// codeword. The weighted syndrome sum(i*x_i) mod (n+1) is then accumulated
// one position per cycle. The check bits at positions 1, 2, 4, ... are set so
// that the final residue equals a.
module vt_strand_encoder #(
    parameter int n = 5,
    parameter int a = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [n-$clog2(n+1)-1:0]     msg,
    output logic [n-1:0]                 strand,
    output logic                         busy,
    output logic                         done
);

    // Number of check bits and message width.
    localparam int M   = $clog2(n + 1);
    localparam int K   = n - M;
    localparam int MOD = n + 1;

    // Constants sized to the arithmetic they feed. One extra bit holds sums
    // that may briefly exceed n.
    localparam logic [M:0]   mod_w    = MOD[M:0];
    localparam logic [M:0]   a_w      = a[M:0];
    localparam logic [M-1:0] last_pos = n[M-1:0];

    // Reject parameter sets that cannot form a valid code.
    generate
        if (n < 3) begin : g_bad_n
            $error("vt_strand_encoder: n must be at least 3");
        end
        if (a < 0 || a > n) begin : g_bad_a
            $error("vt_strand_encoder: a must lie in 0..n");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2
    } state_t;

    // Place message bits on the data positions (the non-powers of two),
    // lowest message bit first. Check positions are left at zero.
    function automatic logic [n-1:0] place_data(input logic [K-1:0] m);
        logic [n-1:0] v;
        int           k;
        v = '0;
        k = 0;
        for (int p = 1; p <= n; p++) begin
            if ((p & (p - 1)) != 0) begin
                v[p-1] = m[k];
                k++;
            end
        end
        return v;
    endfunction

    // Place bit j of the correction value on check position 2^j.
    function automatic logic [n-1:0] place_check(input logic [M-1:0] d);
        logic [n-1:0] v;
        v = '0;
        for (int j = 0; j < M; j++) begin
            v[(1 << j) - 1] = d[j];
        end
        return v;
    endfunction

    state_t       state;
    state_t       state_nxt;

    logic [K-1:0] msg_q;     // message captured on the accepting edge
    logic [M-1:0] acc;       // running syndrome, always in 0..n
    logic [M-1:0] idx;       // position under evaluation, 1..n

    logic         accept;
    logic         step;
    logic         fin;

    logic [n:0]   placed_ext;
    logic         cur_bit;
    logic [M:0]   acc_sum;
    logic [M-1:0] acc_add;
    logic [M:0]   diff;
    logic [M-1:0] d_val;
    logic [n-1:0] code_word;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: registered state always uses non-blocking assignment, so
            // every flop samples values from before the edge and the order of
            // statements does not matter.
            state <= state_nxt;
        end
    end

    // Next-state logic: one pass over positions 1..n, then one FINAL cycle.
    always_comb begin
        // NOTE: assigning a default first means every path drives the
        // variable, so no latch is inferred when a case arm omits it.
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (idx == last_pos) state_nxt = FINAL;
            FINAL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs and datapath strobes decoded from the current state.
    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && start;
        step   = (state == ACCUM);
        fin    = (state == FINAL);
    end

    // Syndrome arithmetic. The modulo is a single conditional subtract because
    // both operands are already below n+1.
    always_comb begin
        placed_ext = {place_data(msg_q), 1'b0};
        cur_bit    = placed_ext[idx];

        acc_sum = {1'b0, acc} + {1'b0, idx};
        if (acc_sum >= mod_w) begin
            acc_sum = acc_sum - mod_w;
        end
        acc_add = acc_sum[M-1:0];

        if ({1'b0, acc} <= a_w) begin
            diff = a_w - {1'b0, acc};
        end else begin
            diff = a_w + mod_w - {1'b0, acc};
        end
        d_val     = diff[M-1:0];
        code_word = place_data(msg_q) | place_check(d_val);
    end

    // Datapath registers: capture, accumulate, then publish the codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q  <= '0;
            acc    <= '0;
            idx    <= '0;
            strand <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                msg_q <= msg;
                acc   <= '0;
                idx   <= M'(1);
            end
            if (step) begin
                if (cur_bit) begin
                    acc <= acc_add;
                end
                idx <= idx + M'(1);
            end
            if (fin) begin
                strand <= code_word;
                done   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vt_strand_encoder.sv
// Testbench for vt_strand_encoder.
// The bench drives two instances, one with n=5, a=3 and one with n=7, a=0.
// Stimulus pushes hand-computed expectations into a queue. A monitor per
// instance pops one expectation and compares it on every done pulse.
`timescale 1ns/1ps
module tb_vt_strand_encoder;

    typedef struct {
        logic [3:0] msg;
        logic [6:0] strand;
        int         due;     // edge number that must register done
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start5, start7;
    logic [1:0] msg5;
    logic [3:0] msg7;
    logic [4:0] strand5;
    logic [6:0] strand7;
    logic       busy5, done5, busy7, done7;

    exp_t       q5[$];
    exp_t       q7[$];
    exp_t       e5, e7;
    logic [6:0] seen7[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    logic       prev_done5 = 1'b0;
    logic       prev_done7 = 1'b0;

    // Hand-computed n=7, a=0 codewords {pos7..pos1} for msg 0..15.
    logic [6:0] tbl7 [16] = '{7'h00, 7'h0D, 7'h13, 7'h14, 7'h22, 7'h2F, 7'h39, 7'h36,
                              7'h41, 7'h4E, 7'h58, 7'h55, 7'h63, 7'h64, 7'h7A, 7'h77};

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc holds k.
    always @(posedge clk) cyc <= cyc + 1;

    vt_strand_encoder #(.n(5), .a(3)) dut5 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start5),
        .msg    (msg5),
        .strand (strand5),
        .busy   (busy5),
        .done   (done5)
    );

    vt_strand_encoder #(.n(7), .a(0)) dut7 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start7),
        .msg    (msg7),
        .strand (strand7),
        .busy   (busy7),
        .done   (done7)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Weighted residue sum(i*x_i) mod (nn+1) of a captured strand.
    function automatic int residue(input logic [6:0] s, input int nn);
        int sum;
        sum = 0;
        for (int i = 1; i <= nn; i++) begin
            if (s[i-1]) sum += i;
        end
        return sum % (nn + 1);
    endfunction

    // Called at a falling edge with the n=5 instance in IDLE. The next rising
    // edge accepts the request. Counting the accepting edge as edge 1, done is
    // registered on edge n+2, which is the accept edge number plus 6.
    task automatic go5(input logic [1:0] m, input logic [4:0] exp);
        exp_t e;
        start5 = 1'b1;
        msg5   = m;
        @(posedge clk);
        #1;
        e.msg    = {2'b00, m};
        e.strand = {2'b00, exp};
        e.due    = cyc + 6;
        q5.push_back(e);
        @(negedge clk);
        start5 = 1'b0;
    endtask

    task automatic go7(input logic [3:0] m, input logic [6:0] exp);
        exp_t e;
        start7 = 1'b1;
        msg7   = m;
        @(posedge clk);
        #1;
        e.msg    = m;
        e.strand = exp;
        e.due    = cyc + 8;
        q7.push_back(e);
        @(negedge clk);
        start7 = 1'b0;
    endtask

    // Wait at falling edges for done, optionally checking busy and toggling msg.
    task automatic wait_done5(input bit chk_busy, input bit toggle);
        for (int i = 0; i < 30; i++) begin
            if (done5) return;
            if (chk_busy) check("busy5_high", busy5, 1);
            if (toggle) msg5 = ~msg5;
            @(negedge clk);
        end
        check("done5_timeout", done5, 1);
    endtask

    task automatic wait_done7();
        for (int i = 0; i < 30; i++) begin
            if (done7) return;
            @(negedge clk);
        end
        check("done7_timeout", done7, 1);
    endtask

    // Monitor for the n=5 instance.
    always @(negedge clk) begin
        if (rst_n && done5) begin
            check("done5_single", prev_done5, 0);
            check("busy5_low_at_done", busy5, 0);
            check("done5_expected", q5.size() != 0, 1);
            if (q5.size() != 0) begin
                e5 = q5.pop_front();
                check("strand5", strand5, e5.strand[4:0]);
                check("latency5", cyc, e5.due);
                check("residue5", residue({2'b00, strand5}, 5), 3);
                check("data5", {strand5[4], strand5[2]}, e5.msg[1:0]);
            end
        end
        prev_done5 = done5;
    end

    // Monitor for the n=7 instance.
    always @(negedge clk) begin
        if (rst_n && done7) begin
            check("done7_single", prev_done7, 0);
            check("busy7_low_at_done", busy7, 0);
            check("done7_expected", q7.size() != 0, 1);
            if (q7.size() != 0) begin
                e7 = q7.pop_front();
                check("strand7", strand7, e7.strand);
                check("latency7", cyc, e7.due);
                check("residue7", residue(strand7, 7), 0);
                check("data7", {strand7[6], strand7[5], strand7[4], strand7[2]}, e7.msg);
                seen7.push_back(strand7);
            end
        end
        prev_done7 = done7;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dups;
        rst_n  = 1'b0;
        start5 = 1'b0;
        start7 = 1'b0;
        msg5   = '0;
        msg7   = '0;
        #23;
        check("reset_strand5", strand5, 0);
        check("reset_busy5", busy5, 0);
        check("reset_done5", done5, 0);
        check("reset_strand7", strand7, 0);
        check("reset_busy7", busy7, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single encode: msg 00 -> 00011.
        go5(2'b00, 5'b00011);
        wait_done5(1'b1, 1'b0);

        // Back-to-back encodes, each started in the done cycle.
        go5(2'b01, 5'b00100);
        wait_done5(1'b0, 1'b0);
        go5(2'b10, 5'b11000);
        wait_done5(1'b0, 1'b0);
        go5(2'b11, 5'b10101);
        wait_done5(1'b0, 1'b0);

        // A start during ACCUM is ignored. strand holds and busy stays high.
        go5(2'b01, 5'b00100);
        check("busy5_accum", busy5, 1);
        check("strand5_hold", strand5, 5'b10101);
        start5 = 1'b1;
        msg5   = 2'b10;
        @(negedge clk);
        start5 = 1'b0;
        check("strand5_hold2", strand5, 5'b10101);
        wait_done5(1'b1, 1'b0);

        // Reset in the third ACCUM cycle aborts the encode asynchronously.
        go5(2'b11, 5'b10101);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_strand5", strand5, 0);
        check("abort_busy5", busy5, 0);
        check("abort_done5", done5, 0);
        void'(q5.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        go5(2'b11, 5'b10101);
        wait_done5(1'b0, 1'b0);

        // msg toggles every cycle after acceptance and must not matter.
        go5(2'b10, 5'b11000);
        wait_done5(1'b0, 1'b1);

        // n=7, a=0: full sweep of all 16 messages, back to back.
        @(negedge clk);
        for (int m = 0; m < 16; m++) begin
            go7(4'(m), tbl7[m]);
            wait_done7();
        end

        for (int i = 0; i < 40; i++) begin
            if (q5.size() == 0 && q7.size() == 0) break;
            @(negedge clk);
        end
        check("q5_drained", q5.size(), 0);
        check("q7_drained", q7.size(), 0);

        dups = 0;
        for (int i = 0; i < seen7.size(); i++) begin
            for (int j = i + 1; j < seen7.size(); j++) begin
                if (seen7[i] == seen7[j]) dups++;
            end
        end
        check("distinct7_count", seen7.size(), 16);
        check("distinct7_dups", dups, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
